dmrs_slot_sequencer: RTL

Slot-level controller for the PUSCH DMRS generator. Once per slot it latches the cell/slot configuration and walks the 14 OFDM symbols of the slot. For each symbol flagged as DMRS it restarts the generator and counts its output samples against the expected length. For each data symbol it performs a request/done handshake with the data mapper. It sits between the slot timing logic and the DMRS generator top, and owns the generator's restart and configuration inputs.

---
 rtl/dmrs_slot_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/dmrs_slot_sequencer.sv
// Slot-level controller for the PUSCH DMRS generator: latches the slot configuration,
// walks the 14 OFDM symbols, restarts/checks the generator and handshakes with the data mapper.
module dmrs_slot_sequencer #(
    parameter int unsigned GEN_RST_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slot_start,
    input  logic [3:0]  N_slot_frame_in,
    input  logic [9:0]  N_cell_ID_in,
    input  logic [6:0]  N_rb_in,
    input  logic [1:0]  En_hopping_in,
    input  logic [13:0] dmrs_sym_mask,
    input  logic        DMRS_valid,
    input  logic        DMRS_finished,
    input  logic        data_done,
    output logic        gen_reset,
    output logic [3:0]  N_slot_frame,
    output logic [9:0]  N_cell_ID,
    output logic [6:0]  N_rb,
    output logic [1:0]  En_hopping,
    output logic [3:0]  sym_idx,
    output logic        sym_is_dmrs,
    output logic        data_req,
    output logic        busy,
    output logic        slot_done,
    output logic        len_err,
    output logic        timeout_err,
    output logic        cfg_err,
    output logic        overrun
);

    localparam int unsigned CNT_W    = 11;
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RST_W    = 3;
    localparam int unsigned SYM_LAST = 13;

    typedef enum logic [2:0] {
        IDLE, LATCH, GEN_RST, GEN_RUN, DATA_WAIT, NEXT, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [13:0]        mask_q, mask_d;
    logic [CNT_W-1:0]   expected_q, expected_d;
    logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d, smp_nxt;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic               tmo_hit;

    logic [3:0]  n_slot_frame_d;
    logic [9:0]  n_cell_id_d;
    logic [6:0]  n_rb_d;
    logic [1:0]  en_hopping_d;
    logic [3:0]  sym_idx_d;
    logic        gen_reset_d, sym_is_dmrs_d, data_req_d, busy_d, slot_done_d;
    logic        len_err_d, timeout_err_d, cfg_err_d, overrun_d;

    // Saturating sample count including a strobe in the current cycle
    assign smp_nxt = (DMRS_valid && (smp_cnt_q != {CNT_W{1'b1}})) ? smp_cnt_q + CNT_W'(1) : smp_cnt_q;
    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        expected_d     = expected_q;
        smp_cnt_d      = smp_cnt_q;
        tmo_cnt_d      = '0;
        rst_cnt_d      = '0;
        n_slot_frame_d = N_slot_frame;
        n_cell_id_d    = N_cell_ID;
        n_rb_d         = N_rb;
        en_hopping_d   = En_hopping;
        sym_idx_d      = sym_idx;
        len_err_d      = len_err;
        timeout_err_d  = timeout_err;
        cfg_err_d      = cfg_err;
        overrun_d      = slot_start && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (slot_start) begin
                    n_slot_frame_d = N_slot_frame_in;
                    n_cell_id_d    = N_cell_ID_in;
                    n_rb_d         = N_rb_in;
                    en_hopping_d   = En_hopping_in;
                    mask_d         = dmrs_sym_mask;
                    sym_idx_d      = '0;
                    len_err_d      = 1'b0;
                    timeout_err_d  = 1'b0;
                    cfg_err_d      = 1'b0;
                    state_d        = LATCH;
                end
            end
            LATCH: begin
                sym_idx_d = '0;
                if (N_rb == 7'd0) begin
                    cfg_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    expected_d = CNT_W'(N_rb) * CNT_W'(12);
                    state_d    = mask_q[0] ? GEN_RST : DATA_WAIT;
                end
            end
            GEN_RST: begin
                smp_cnt_d = '0;
                if (rst_cnt_q == RST_W'(GEN_RST_CYCLES - 1)) state_d = GEN_RUN;
                else rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
            GEN_RUN: begin
                smp_cnt_d = smp_nxt;
                if (DMRS_finished) begin
                    if (smp_nxt != expected_q) len_err_d = 1'b1;
                    state_d = NEXT;
                end else if (tmo_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = NEXT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            DATA_WAIT: begin
                if (data_done) begin
                    state_d = NEXT;
                end else if (tmo_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = NEXT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            NEXT: begin
                if (sym_idx == 4'(SYM_LAST)) begin
                    state_d = DONE;
                end else begin
                    sym_idx_d = sym_idx + 4'd1;
                    state_d   = mask_q[sym_idx_d] ? GEN_RST : DATA_WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs decode the state being entered so they are registered without extra lag
        gen_reset_d   = (state_d == GEN_RST);
        data_req_d    = (state_d == DATA_WAIT);
        busy_d        = (state_d != IDLE);
        slot_done_d   = (state_d == DONE);
        sym_is_dmrs_d = busy_d && mask_d[sym_idx_d];
    end

    // gen_reset sets asynchronously so the generator is held restarted during reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q       <= '0;
            expected_q   <= '0;
            smp_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            N_slot_frame <= '0;
            N_cell_ID    <= '0;
            N_rb         <= '0;
            En_hopping   <= '0;
            sym_idx      <= '0;
            gen_reset    <= 1'b1;
            sym_is_dmrs  <= 1'b0;
            data_req     <= 1'b0;
            busy         <= 1'b0;
            slot_done    <= 1'b0;
            len_err      <= 1'b0;
            timeout_err  <= 1'b0;
            cfg_err      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            mask_q       <= mask_d;
            expected_q   <= expected_d;
            smp_cnt_q    <= smp_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            N_slot_frame <= n_slot_frame_d;
            N_cell_ID    <= n_cell_id_d;
            N_rb         <= n_rb_d;
            En_hopping   <= en_hopping_d;
            sym_idx      <= sym_idx_d;
            gen_reset    <= gen_reset_d;
            sym_is_dmrs  <= sym_is_dmrs_d;
            data_req     <= data_req_d;
            busy         <= busy_d;
            slot_done    <= slot_done_d;
            len_err      <= len_err_d;
            timeout_err  <= timeout_err_d;
            cfg_err      <= cfg_err_d;
            overrun      <= overrun_d;
        end
    end

endmodule
